rat_intr_ctrl: RTL and testbench

RAT_INTR_CTRL -- requirements
Module: rat_intr_ctrl

---
 rtl/rat_intr_ctrl.sv | 132 +++++++++++++
 tb/tb_rat_intr_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller: edge-detected requests, mask/pending/cause IO registers,
// and a single-level IDLE -> ASSERT -> SERVICE handshake with the control unit.
module rat_intr_ctrl #(
   parameter int          NUM_SRC    = 4,
   parameter logic [7:0]  MASK_PORT  = 8'hF0,
   parameter logic [7:0]  CAUSE_PORT = 8'hF1,
   parameter logic [7:0]  PEND_PORT  = 8'hF2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               int_en,
   input  logic               int_ack,
   input  logic               reti,
   input  logic [7:0]         port_id,
   input  logic [7:0]         out_port,
   input  logic               io_strb,
   output logic [7:0]         rd_data,
   output logic               interrupt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [NUM_SRC-1:0] irq_prev;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] pend_nx;
   logic [2:0]         cause;
   logic [2:0]         low_idx;
   logic               primed;
   logic               take_ack;
   logic [7:0]         mask_ext;
   logic [7:0]         pend_ext;
   logic               unused_out_port;

   function automatic logic [2:0] lowest_set(input logic [NUM_SRC-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // primed stays 0 for the first edge after reset so a line already held
   // high is captured into irq_prev without being seen as a rising edge.
   assign edge_det = irq_src & ~irq_prev & {NUM_SRC{primed}};
   assign active   = pending & mask;
   assign low_idx  = lowest_set(active);
   assign take_ack = (state == S_ASSERT) && int_ack;
   assign w1c      = (io_strb && (port_id == PEND_PORT)) ? out_port[NUM_SRC-1:0] : '0;

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = take_ack && active[i] && (low_idx == 3'(i));
      end
   end

   // A new edge wins over any clear of the same bit in the same cycle.
   assign pend_nx = (pending & ~w1c & ~ack_clr) | edge_det;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if ((|active) && int_en) state_nx = S_ASSERT;
         end
         S_ASSERT: begin
            if (int_ack)                     state_nx = S_SERVICE;
            else if (!int_en || !(|active))  state_nx = S_IDLE;
         end
         S_SERVICE: begin
            if (reti) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         interrupt <= 1'b0;
      end else begin
         state     <= state_nx;
         interrupt <= (state_nx == S_ASSERT);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_prev <= '0;
         primed   <= 1'b0;
         pending  <= '0;
         mask     <= '0;
         cause    <= '0;
      end else begin
         irq_prev <= irq_src;
         primed   <= 1'b1;
         pending  <= pend_nx;
         if (io_strb && (port_id == MASK_PORT)) mask <= out_port[NUM_SRC-1:0];
         if (take_ack && (|active)) cause <= low_idx;
      end
   end

   always_comb begin
      mask_ext                = '0;
      pend_ext                = '0;
      mask_ext[NUM_SRC-1:0]   = mask;
      pend_ext[NUM_SRC-1:0]   = pending;
   end

   always_comb begin
      rd_data = '0;
      if (port_id == MASK_PORT)       rd_data = mask_ext;
      else if (port_id == CAUSE_PORT) rd_data = {5'b0, cause};
      else if (port_id == PEND_PORT)  rd_data = pend_ext;
   end

   assign unused_out_port = ^out_port;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Scoreboarded bench for rat_intr_ctrl: driver pushes model predictions,
// a negedge monitor pops and compares interrupt and rd_data every cycle.
`timescale 1ns/1ps
module tb_rat_intr_ctrl;

   localparam logic [7:0] MP = 8'hF0;
   localparam logic [7:0] CP = 8'hF1;
   localparam logic [7:0] PP = 8'hF2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] irq_src;
   logic       int_en, int_ack, reti, io_strb;
   logic [7:0] port_id, out_port;
   logic [7:0] rd_data;
   logic       interrupt;

   rat_intr_ctrl #(.NUM_SRC(4), .MASK_PORT(MP), .CAUSE_PORT(CP), .PEND_PORT(PP)) dut (
      .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .int_en(int_en),
      .int_ack(int_ack), .reti(reti), .port_id(port_id), .out_port(out_port),
      .io_strb(io_strb), .rd_data(rd_data), .interrupt(interrupt)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic       irq;
      logic [7:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   // Reference model: request bookkeeping as plain bit vectors and two flags
   bit [3:0] m_pend, m_mask, m_prev;
   int       m_cause;
   bit       m_asserting, m_in_service;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks_total++;
      if (act === req) checks_passed++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] pid);
      if (pid == MP) return {4'b0, m_mask};
      if (pid == CP) return 8'(m_cause);
      if (pid == PP) return {4'b0, m_pend};
      return 8'h00;
   endfunction

   function automatic void model_reset();
      m_pend = '0; m_mask = '0; m_cause = 0;
      m_asserting = 0; m_in_service = 0;
      m_prev = 4'hF;  // held-high lines after reset are not requests
   endfunction

   function automatic void model_clock(input bit [3:0] src, input bit en, input bit ack,
                                       input bit rt, input logic [7:0] pid,
                                       input logic [7:0] data, input bit strb);
      bit [3:0] edges, act, npend;
      int lo;
      edges = src & ~m_prev;
      act   = m_pend & m_mask;
      lo    = -1;
      for (int i = 0; i < 4; i++) if (act[i] && lo < 0) lo = i;
      npend = m_pend;
      if (strb && pid == PP) npend &= ~data[3:0];
      if (m_asserting) begin
         if (ack) begin
            m_asserting = 0; m_in_service = 1;
            if (lo >= 0) begin m_cause = lo; npend[lo] = 1'b0; end
         end else if (!en || act == 0) m_asserting = 0;
      end else if (m_in_service) begin
         if (rt) m_in_service = 0;
      end else if (act != 0 && en) m_asserting = 1;
      m_pend = npend | edges;
      if (strb && pid == MP) m_mask = data[3:0];
      m_prev = src;
   endfunction

   task automatic step(input bit [3:0] src, input bit en, input bit ack, input bit rt,
                       input logic [7:0] pid, input logic [7:0] data, input bit strb);
      @(posedge clk); #1;
      reset_n = 1'b1; irq_src = src; int_en = en; int_ack = ack; reti = rt;
      port_id = pid; out_port = data; io_strb = strb;
      q.push_back('{irq: m_asserting, rd: model_read(pid)});
      model_clock(src, en, ack, rt, pid, data, strb);
   endtask

   task automatic rst_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         reset_n = 1'b0; int_ack = 0; reti = 0; io_strb = 0;
         port_id = (k % 3 == 0) ? MP : (k % 3 == 1) ? CP : PP;
         model_reset();
         q.push_back('{irq: 1'b0, rd: 8'h00});
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("interrupt", {7'b0, interrupt}, {7'b0, e.irq});
            check("rd_data", rd_data, e.rd);
         end
      end
   end

   initial begin : driver
      bit [3:0] src_r;
      logic [7:0] pid;
      reset_n = 1'b0; irq_src = '0; int_en = 0; int_ack = 0; reti = 0;
      port_id = '0; out_port = '0; io_strb = 0;
      model_reset();
      rst_cycles(3);

      // mask 0101, pulse source 2, ack -> cause 2
      step(4'h0, 1, 0, 0, MP, 8'h05, 1);
      step(4'h4, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 1, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, CP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 1, MP, 8'h00, 0);

      // simultaneous sources 3 and 1: lowest serviced first, then 3
      rst_cycles(2);
      step(4'h0, 1, 0, 0, MP, 8'h0F, 1);
      step(4'hA, 1, 0, 0, PP, 8'h00, 0);
      step(4'hA, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 1, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, CP, 8'h00, 0);
      step(4'h0, 1, 0, 1, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 1, 0, CP, 8'h00, 0);
      step(4'h0, 1, 0, 0, CP, 8'h00, 0);
      step(4'h0, 1, 0, 1, PP, 8'h00, 0);

      // int_en gating, pending retained when enable drops before ack
      rst_cycles(2);
      step(4'h0, 0, 0, 0, MP, 8'h0F, 1);
      step(4'h1, 0, 0, 0, PP, 8'h00, 0);
      for (int k = 0; k < 3; k++) step(4'h0, 0, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 0, 0, 0, PP, 8'h00, 0);
      step(4'h0, 0, 0, 0, PP, 8'h00, 0);

      // W1C of bit 0 in the same cycle as a new edge on source 0
      rst_cycles(2);
      step(4'h1, 0, 0, 0, PP, 8'h00, 0);
      step(4'h0, 0, 0, 0, PP, 8'h00, 0);
      step(4'h1, 0, 0, 0, PP, 8'h01, 1);
      step(4'h1, 0, 0, 0, PP, 8'h00, 0);

      // edge during SERVICE stays pending until reti
      rst_cycles(2);
      step(4'h0, 1, 0, 0, MP, 8'h0F, 1);
      step(4'h2, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 1, 0, PP, 8'h00, 0);
      step(4'h1, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 1, CP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);

      // asynchronous reset in the middle of an ASSERT cycle
      step(4'h0, 1, 0, 0, MP, 8'h00, 0);
      @(posedge clk); #1;
      int_ack = 0; reti = 0; io_strb = 0; port_id = MP;
      #2 reset_n = 1'b0;
      #1 check("async_reset_interrupt", {7'b0, interrupt}, 8'h00);
      check("async_reset_mask", rd_data, 8'h00);
      port_id = CP;
      #1 check("async_reset_cause", rd_data, 8'h00);
      port_id = PP;
      #1 check("async_reset_pending", rd_data, 8'h00);
      model_reset();
      rst_cycles(3);

      // held-high line across reset release is not a request
      irq_src = 4'h3;
      rst_cycles(2);
      step(4'h3, 1, 0, 0, MP, 8'h0F, 1);
      step(4'h3, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);
      step(4'h0, 1, 0, 0, PP, 8'h00, 0);

      // randomized traffic
      src_r = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) rst_cycles(2);
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) src_r[b] = ~src_r[b];
         case ($urandom_range(0, 3))
            0:       pid = MP;
            1:       pid = CP;
            2:       pid = PP;
            default: pid = 8'($urandom);
         endcase
         step(src_r,
              $urandom_range(0, 9) != 0,
              m_asserting  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0),
              m_in_service ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
              pid, 8'($urandom), $urandom_range(0, 9) == 0);
      end

      @(negedge clk); #1;
      if (q.size() != 0) begin
         checks_total++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
